// File: rtl/gb_irq_pkg.sv
// Shared constants for the Game Boy interrupt controller: vector layout,
// default register addresses and the source index enumeration.
package gb_irq_pkg;

  localparam logic [15:0] IRQ_VEC_BASE    = 16'h0040;
  localparam logic [15:0] IRQ_VEC_STRIDE  = 16'd8;
  localparam logic [15:0] ADDR_IF_DEFAULT = 16'hFF0F;
  localparam logic [15:0] ADDR_IE_DEFAULT = 16'hFFFF;
  localparam int          IRQ_MAX         = 8;

  typedef enum logic [2:0] {
    IRQ_VBLANK = 3'd0,
    IRQ_STAT   = 3'd1,
    IRQ_TIMER  = 3'd2,
    IRQ_SERIAL = 3'd3,
    IRQ_JOYPAD = 3'd4
  } irq_src_e;

endpackage

// File: rtl/gb_irq_prio_enc.sv
// Fixed-priority encoder: reports the index of the lowest set bit of vec,
// bit 0 being the highest priority.
module gb_irq_prio_enc #(
  parameter int N = 5
) (
  input  logic [N-1:0] vec,
  output logic         valid,
  output logic [2:0]   idx
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    valid = |vec;
    idx   = 3'd0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = 3'(i);
    end
  end

endmodule

// File: rtl/gb_interrupt_ctrl.sv
// IF/IE interrupt controller beside gb_cpu: edge-detected requests, fixed
// priority, CPU bus access and ack clear. Define GB_IRQ_SYNC_EN to add a
// two-flop synchroniser on each request line.
module gb_interrupt_ctrl
  import gb_irq_pkg::*;
#(
  parameter int          NUM_IRQ = 5,
  parameter logic [15:0] ADDR_IF = ADDR_IF_DEFAULT,
  parameter logic [15:0] ADDR_IE = ADDR_IE_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [15:0]        addr,
  input  logic [7:0]         data_i,
  input  logic               wren,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic               clear_interrupt_flag,
  output logic [7:0]         data_o,
  output logic               hit,
  output logic [7:0]         reg_IF,
  output logic [7:0]         reg_IE,
  output logic               irq_pending,
  output logic [15:0]        irq_vector
);

  localparam logic [NUM_IRQ-1:0] IRQ_ONE = NUM_IRQ'(1);

  logic [NUM_IRQ-1:0] irq_i_s;
  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] if_q;
  logic [NUM_IRQ-1:0] if_next;
  logic [7:0]         ie_q;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] pend_vec;
  logic               pend_valid;
  logic [2:0]         pend_idx;
  logic               sel_if;
  logic               sel_ie;

`ifdef GB_IRQ_SYNC_EN
  logic [NUM_IRQ-1:0] sync_p0;
  logic [NUM_IRQ-1:0] sync_p1;

  // Synchroniser stages p0 -> p1 for requests from a foreign clock domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= irq_i;
      sync_p1 <= sync_p0;
    end
  end

  assign irq_i_s = sync_p1;
`else
  assign irq_i_s = irq_i;
`endif

  assign sel_if   = (addr == ADDR_IF);
  assign sel_ie   = (addr == ADDR_IE);
  assign rise     = irq_i_s & ~irq_q;
  assign pend_vec = if_q & ie_q[NUM_IRQ-1:0];

  gb_irq_prio_enc #(.N(NUM_IRQ)) u_prio (
    .vec   (pend_vec),
    .valid (pend_valid),
    .idx   (pend_idx)
  );

  // Ack, then CPU write, then new requests: a fresh edge always survives.
  always_comb begin
    if_next = if_q;
    if (clear_interrupt_flag && pend_valid) if_next = if_next & ~(IRQ_ONE << pend_idx);
    if (wren && sel_if) if_next = data_i[NUM_IRQ-1:0];
    if_next = if_next | rise;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_q  <= '0;
      ie_q  <= 8'h00;
      irq_q <= '0;
    end else begin
      if_q  <= if_next;
      irq_q <= irq_i_s;
      if (wren && sel_ie) ie_q <= data_i;
    end
  end

  // Unimplemented IF bits read as 1, matching the real hardware.
  always_comb begin
    reg_IF              = 8'hFF;
    reg_IF[NUM_IRQ-1:0] = if_q;
  end

  assign reg_IE      = ie_q;
  assign hit         = sel_if | sel_ie;
  assign irq_pending = pend_valid;
  assign irq_vector  = pend_valid ? (IRQ_VEC_BASE + 16'(pend_idx) * IRQ_VEC_STRIDE) : 16'h0000;

  always_comb begin
    data_o = 8'h00;
    if (sel_if)      data_o = reg_IF;
    else if (sel_ie) data_o = reg_IE;
  end

endmodule

// File: doc/gb_interrupt_ctrl.md
# gb_interrupt_ctrl

Parametrised interrupt controller owning the IF (0xFF0F) and IE (0xFFFF) registers for the Game Boy system. It replaces the ad-hoc IF set/clear logic that lived in the CPU bench: it edge-detects up to eight peripheral request lines, arbitrates by fixed priority, serves CPU bus reads and writes of IF and IE, and clears the serviced flag when the CPU acknowledges. It sits beside `gb_cpu` on the CPU address/data bus and drives the CPU's `reg_IF` and `reg_IE` inputs.

## Interface
- NUM_IRQ, 5, number of request sources (1..8); bit 0 is highest priority
- ADDR_IF, 16'hFF0F, bus address of IF
- ADDR_IE, 16'hFFFF, bus address of IE
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- addr  in  16  CPU address bus (`addr_o` of `gb_cpu`)
- data_i  in  8  CPU write data (`data_o` of `gb_cpu`)
- wren  in  1  CPU write strobe (`drive_data_bus`)
- irq_i  in  NUM_IRQ  peripheral request lines, level; rising edge raises a flag
- clear_interrupt_flag  in  1  CPU acknowledge; clears the serviced flag
- data_o  out  8  read data when `hit` is high, else 8'h00
- hit  out  1  `addr` equals ADDR_IF or ADDR_IE
- reg_IF  out  8  IF view: bits [7:NUM_IRQ] read 1, bits [NUM_IRQ-1:0] hold flags
- reg_IE  out  8  IE register, all 8 bits stored
- irq_pending  out  1  |(IF & IE) over bits [NUM_IRQ-1:0]
- irq_vector  out  16  16'h0040 + 8*idx of highest-priority pending and enabled source; 16'h0000 when none

## Operation
- State: `if_q[NUM_IRQ-1:0]`, `ie_q[7:0]`, `irq_q[NUM_IRQ-1:0]` (previous sample of requests).
- Edge detect: `rise = irq_i_s & ~irq_q`; `irq_q <= irq_i_s` every cycle.
- IF next-state, applied in order: start from `if_q`; if ack, clear bit idx of highest-priority `if_q & ie_q[NUM_IRQ-1:0]`; if `wren && addr==ADDR_IF`, replace with `data_i[NUM_IRQ-1:0]` (write overrides ack); finally OR in `rise` (new request always wins).
- Ack with no pending-and-enabled bit: IF unchanged (no clear of disabled flags).
- IE: `wren && addr==ADDR_IE` loads `data_i[7:0]`; otherwise holds.
- Reads: combinational; `data_o` = `reg_IF` at ADDR_IF, `reg_IE` at ADDR_IE, 8'h00 otherwise.
- `irq_pending`, `irq_vector` combinational from current `if_q`/`ie_q`.

## Timing
- Reset values: `if_q`=0, `ie_q`=0, `irq_q`=0, sync flops 0; so `reg_IF`=~((1<<NUM_IRQ)-1) (8'hE0 at default), `reg_IE`=8'h00, `irq_pending`=0, `irq_vector`=16'h0000, `data_o`=8'h00 unless `hit`.
- Request latency: `irq_i` high before edge N → flag visible after edge N (0 cycles sync, +2 with sync enabled).
- A level held high raises the flag once; re-raise requires a low sample between.
- A request line high when reset releases is taken as a rising edge on the first clock.
- Ack and write: effect visible after the same edge; one ack clears exactly one bit.
- Reset asserted mid-cycle clears state immediately, independent of clk.

## Configuration
- `GB_IRQ_SYNC_EN` defined: each `irq_i` bit passes through a two-flop synchroniser (`irq_i_s`) before edge detection; latency +2 cycles; for sources on another clock.
- Undefined: `irq_i_s = irq_i` directly; sources must be synchronous to `clk`.

## Structure
- Package `gb_irq_pkg`: constants `IRQ_VEC_BASE`=16'h0040, `IRQ_VEC_STRIDE`=8, `ADDR_IF_DEFAULT`, `ADDR_IE_DEFAULT`, `IRQ_MAX`=8, enum of source indices (VBLANK, STAT, TIMER, SERIAL, JOYPAD).
- One sub-module `gb_irq_prio_enc` (parameter N): input vector, outputs `valid` and `idx[2:0]` of lowest set bit; used for both ack clear and vector.

## Test plan
- Reset, read 0xFF0F and 0xFFFF → `data_o` 8'hE0 and 8'h00; `irq_pending`=0.
- Write IE=8'h04, pulse `irq_i[2]` one cycle → `reg_IF`=8'hE4 next edge, `irq_pending`=1, `irq_vector`=16'h0050; ack → `reg_IF`=8'hE0.
- IE=8'h1F, raise `irq_i[4]` and `irq_i[1]` together → IF=8'hF2, vector 16'h0048; ack → IF=8'hF0, vector 16'h0060; ack → 8'hE0.
- IE=8'h00, IF flags 8'hE3, ack → IF stays 8'hE3; `irq_pending`=0, vector 16'h0000.
- Same edge: CPU writes IF=8'h00 and `irq_i[0]` rises → IF=8'hE1; hold `irq_i[0]` high, write IF=8'h00 → stays 8'hE0.
- With `GB_IRQ_SYNC_EN`: `irq_i[3]` rises before edge N → IF bit 3 first visible after edge N+2; assert reset mid-stream → all outputs at reset values without a clock edge.
